vga_text_pixel_gen: RTL and testbench
=====================================

Name: vga_text_pixel_gen

Overview:
- Display stage directly downstream of the AXI-Lite VGA slave register block.
- Consumes the slave's colour and cursor registers and the character buffer, and produces 640x480@60 VGA timing and 12-bit RGB pixels for an 80x30 text screen with 8x16 glyphs.
- Character buffer RAM and font ROM are external synchronous-read memories.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- COLS, 80, text columns (H_ACTIVE/8)
- BLINK_FRAMES, 32, frames per cursor blink phase

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel strobe, one ACLK wide, 1-in-4 at 100 MHz
- fg_color  in  12  foreground RGB444 from slave register
- bg_color  in  12  background RGB444
- cursor_col  in  7  cursor column 0..79
- cursor_row  in  5  cursor row 0..29
- cursor_en  in  1  cursor display enable
- char_addr  out  12  character RAM read address (row*COLS+col)
- char_data  in  8  character code, valid 1 ACLK after char_addr
- font_addr  out  12  {char_code[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row bits, MSB = leftmost pixel, valid 1 ACLK after font_addr
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high for visible pixels
- red, green, blue  out  4 each  pixel colour
- frame_start  out  1  one-ACLK pulse marking output pixel (0,0)

Behaviour:
- Reset (asynchronous, ARESETN=0): h_cnt=0, v_cnt=0, blink counter=0, blink phase=0, all pipeline registers=0. Outputs: hsync=1, vsync=1, video_on=0, rgb=0, frame_start=0, char_addr=0, font_addr=0. Latched colours=0, cursor latch disabled.
- All state advances only on ACLK edges where pix_ce=1. With pix_ce=0 every register holds, except that frame_start clears after one ACLK.
- Stage 0 counters:
  - h_cnt 0..799 wraps to 0 and increments v_cnt.
  - v_cnt 0..524 wraps to 0.
  - Sync is low for h_cnt 656..751 and v_cnt 490..491.
  - Visible when h_cnt<640 and v_cnt<480.
- Stage 1: char_addr <= (v_cnt>>4)*COLS + (h_cnt>>3), computed in 12 bits. Carry sub_x=h_cnt[2:0], sub_y=v_cnt[3:0], sync, visible and the cursor-cell match flag.
- Stage 2: font_addr <= {char_data, sub_y}. Carry side-band signals.
- Stage 3:
  - bit = font_data[7-sub_x].
  - rgb <= visible ? (bit ^ cursor_invert ? fg : bg) : 0.
  - hsync, vsync and video_on are registered from the same stage.
- Latency: the output for counter position (x,y) appears 3 pix_ce ticks after the counter holds (x,y). Sync and video_on are delayed identically, so no skew.
- Non-visible cells: char_addr and font_addr still update; values are don't-care, but rgb is forced to 0.
- Register latching: fg_color, bg_color, cursor_col, cursor_row and cursor_en are latched when stage-0 wraps to (0,0). Mid-frame changes therefore take effect on the next frame (no tearing).
- Cursor:
  - cursor_invert = cursor_en_latched & blink_phase & (cell == latched cursor cell).
  - Blink counter increments at each frame wrap.
  - At BLINK_FRAMES-1 the counter resets to 0 and blink_phase toggles.
- frame_start: asserted for the single ACLK following the pix_ce tick on which stage 3 outputs pixel (0,0).
- Out-of-range cursor (col>79 or row>29): no cell matches, so no inversion.

Test Plan:
- Reset then release, pix_ce every 4th ACLK -> hsync=1, vsync=1, rgb=0 during reset. First frame_start 3 pix_ce ticks after the counter reaches (0,0).
- Free-run 2 frames -> hsync low exactly 96 ticks per 800. vsync low exactly 2 lines (1600 ticks) per 525 lines. video_on high 640x480 ticks per frame.
- Counter at pixel (17,35) -> char_addr = 2*80+2 = 162. Memory model returns 0x41 -> font_addr = 0x413. font_data=0x80, fg=0xF00, bg=0x00F -> output at x=16 is 0xF00, at x=17 is 0x00F.
- cursor_en=1 at (5,3), all glyphs blank, bg=0x000, fg=0xFFF -> frames 0..31: cell uninverted (0x000). Frames 32..63: all 128 cell pixels read 0xFFF.
- Change fg_color mid-frame (line 200) -> remainder of the frame uses the old colour. The next frame from pixel (0,0) uses the new colour.
- Hold pix_ce low 50 ACLK mid-line -> all outputs frozen. Then assert ARESETN=0 mid-frame -> immediate reset values; after release, timing restarts from (0,0).

Source files
------------

// File: rtl/vga_text_pixel_gen.sv
// vga_text_pixel_gen: 640x480@60 text-mode timing and 4-stage pixel pipeline using external char RAM and font ROM
module vga_text_pixel_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int COLS         = 80,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        pix_ce,
    input  logic [11:0] fg_color,
    input  logic [11:0] bg_color,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_S   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_S   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

    logic [9:0]    h_q, h_d, v_q, v_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [11:0]   fg_l_q, fg_l_d, bg_l_q, bg_l_d;
    logic [6:0]    cur_col_q, cur_col_d;
    logic [4:0]    cur_row_q, cur_row_d;
    logic          cur_en_q, cur_en_d;
    logic [11:0]   char_addr_q, char_addr_d;
    logic [2:0]    sx1_q, sx1_d, sx2_q, sx2_d;
    logic [3:0]    sy1_q, sy1_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d, inv1_q, inv1_d, org1_q, org1_d;
    logic [11:0]   font_addr_q, font_addr_d;
    logic          hs2_q, hs2_d, vs2_q, vs2_d, vis2_q, vis2_d, inv2_q, inv2_d, org2_q, org2_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic          frame_start_q, frame_start_d;
    logic          wrap_h, wrap_f, vis0, pix_bit;

    always_comb begin
        wrap_h        = h_q == H_LAST;
        wrap_f        = wrap_h && v_q == V_LAST;
        h_d           = wrap_h ? 10'd0 : h_q + 10'd1;
        v_d           = wrap_h ? (v_q == V_LAST ? 10'd0 : v_q + 10'd1) : v_q;
        // Screen-wide settings only change at the frame boundary so a frame never tears
        fg_l_d        = wrap_f ? fg_color : fg_l_q;
        bg_l_d        = wrap_f ? bg_color : bg_l_q;
        cur_col_d     = wrap_f ? cursor_col : cur_col_q;
        cur_row_d     = wrap_f ? cursor_row : cur_row_q;
        cur_en_d      = wrap_f ? cursor_en : cur_en_q;
        blink_cnt_d   = wrap_f ? (blink_cnt_q == B_LAST ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
        blink_d       = (wrap_f && blink_cnt_q == B_LAST) ? ~blink_q : blink_q;
        vis0          = h_q < H_VIS && v_q < V_VIS;
        char_addr_d   = 12'(int'(v_q[9:4]) * COLS + int'(h_q[9:3]));
        sx1_d         = h_q[2:0];
        sy1_d         = v_q[3:0];
        hs1_d         = h_q >= HS_S && h_q < HS_E;
        vs1_d         = v_q >= VS_S && v_q < VS_E;
        vis1_d        = vis0;
        inv1_d        = cur_en_q && blink_q && vis0 && h_q[9:3] == cur_col_q && v_q[9:4] == {1'b0, cur_row_q};
        org1_d        = h_q == 10'd0 && v_q == 10'd0;
        font_addr_d   = {char_data, sy1_q};
        sx2_d         = sx1_q;
        hs2_d         = hs1_q;
        vs2_d         = vs1_q;
        vis2_d        = vis1_q;
        inv2_d        = inv1_q;
        org2_d        = org1_q;
        pix_bit       = font_data[3'd7 - sx2_q];
        rgb_d         = vis2_q ? ((pix_bit ^ inv2_q) ? fg_l_q : bg_l_q) : 12'h000;
        hsync_d       = ~hs2_q;
        vsync_d       = ~vs2_q;
        video_on_d    = vis2_q;
        frame_start_d = pix_ce && org2_q;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            h_q           <= '0;
            v_q           <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            fg_l_q        <= '0;
            bg_l_q        <= '0;
            cur_col_q     <= '0;
            cur_row_q     <= '0;
            cur_en_q      <= 1'b0;
            char_addr_q   <= '0;
            sx1_q         <= '0;
            sy1_q         <= '0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            vis1_q        <= 1'b0;
            inv1_q        <= 1'b0;
            org1_q        <= 1'b0;
            font_addr_q   <= '0;
            sx2_q         <= '0;
            hs2_q         <= 1'b0;
            vs2_q         <= 1'b0;
            vis2_q        <= 1'b0;
            inv2_q        <= 1'b0;
            org2_q        <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (pix_ce) begin
                h_q         <= h_d;
                v_q         <= v_d;
                blink_cnt_q <= blink_cnt_d;
                blink_q     <= blink_d;
                fg_l_q      <= fg_l_d;
                bg_l_q      <= bg_l_d;
                cur_col_q   <= cur_col_d;
                cur_row_q   <= cur_row_d;
                cur_en_q    <= cur_en_d;
                char_addr_q <= char_addr_d;
                sx1_q       <= sx1_d;
                sy1_q       <= sy1_d;
                hs1_q       <= hs1_d;
                vs1_q       <= vs1_d;
                vis1_q      <= vis1_d;
                inv1_q      <= inv1_d;
                org1_q      <= org1_d;
                font_addr_q <= font_addr_d;
                sx2_q       <= sx2_d;
                hs2_q       <= hs2_d;
                vs2_q       <= vs2_d;
                vis2_q      <= vis2_d;
                inv2_q      <= inv2_d;
                org2_q      <= org2_d;
                rgb_q       <= rgb_d;
                hsync_q     <= hsync_d;
                vsync_q     <= vsync_d;
                video_on_q  <= video_on_d;
            end
            frame_start_q <= frame_start_d;
        end
    end

    assign char_addr   = char_addr_q;
    assign font_addr   = font_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_text_pixel_gen.sv
// tb_vga_text_pixel_gen: scoreboard bench on a shrunken 32x48 raster (40x54 total) so several frames fit in a short run
module tb_vga_text_pixel_gen;
    localparam int HT = 40;
    localparam int VT = 54;
    localparam int F  = HT * VT;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        pix_ce = 1'b0;
    logic [11:0] fg_color, bg_color;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_en;
    logic [11:0] char_addr, font_addr;
    logic [7:0]  char_data, font_data;
    logic        hsync, vsync, video_on, frame_start;
    logic [3:0]  red, green, blue;

    typedef struct {
        int t;
        int k;
        int v;
    } exp_t;
    exp_t q[$];
    string names [7] = '{"rgb", "hsync", "vsync", "video_on", "char_addr", "font_addr", "frame_start"};
    int tick = 0, vectors = 0, errors = 0;
    int hs_low = 0, vs_low = 0, von_cnt = 0, fs_cnt = 0;
    bit ce_run = 1'b0;
    int ph = 0;

    vga_text_pixel_gen #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .COLS(4), .BLINK_FRAMES(2)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .pix_ce(pix_ce),
        .fg_color(fg_color), .bg_color(bg_color),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    always #5 ACLK = ~ACLK;

    // Cell 10 (row 2, col 2) holds 'A'; only glyph row 3 of 'A' has a pixel, at its leftmost column
    always @(posedge ACLK) begin
        char_data <= (char_addr == 12'd10) ? 8'h41 : 8'h00;
        font_data <= (font_addr == 12'h413) ? 8'h80 : 8'h00;
    end

    initial forever begin
        @(negedge ACLK);
        ph = (ph + 1) % 4;
        pix_ce = ce_run && ph == 0;
    end

    function int actual(int k);
        case (k)
            0: return int'({red, green, blue});
            1: return int'(hsync);
            2: return int'(vsync);
            3: return int'(video_on);
            4: return int'(char_addr);
            5: return int'(font_addr);
            default: return int'(frame_start);
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge ACLK);
            if (!ARESETN) tick = 0;
            else if (pix_ce) begin
                tick++;
                #1;
                if (tick >= F && tick < 3 * F) begin
                    if (!hsync) hs_low++;
                    if (!vsync) vs_low++;
                    if (video_on) von_cnt++;
                end
                while (q.size() > 0 && q[0].t <= tick) begin
                    e = q.pop_front();
                    vectors++;
                    if (e.t < tick || actual(e.k) != e.v) begin
                        errors++;
                        $display("FAIL %s @tick %0d: got 0x%0h, expected 0x%0h", names[e.k], e.t, actual(e.k), e.v);
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge ACLK);
        #2;
        if (frame_start) fs_cnt++;
    end

    task automatic check(string n, int a, int x);
        vectors++;
        if (a != x) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, x);
        end
    endtask

    task automatic px(int f, int x, int y, int k, int v);
        q.push_back('{f * F + y * HT + x + (k == 4 ? 1 : k == 5 ? 2 : 3), k, v});
    endtask

    task automatic wait_tick(int t);
        int n = 0;
        while (tick < t && n < 20000) begin
            @(negedge ACLK);
            n++;
        end
        check("wait_tick reached", int'(tick >= t), 1);
    endtask

    task automatic check_reset(string tag);
        check({tag, " hsync"}, int'(hsync), 1);
        check({tag, " vsync"}, int'(vsync), 1);
        check({tag, " video_on"}, int'(video_on), 0);
        check({tag, " rgb"}, int'({red, green, blue}), 0);
        check({tag, " frame_start"}, int'(frame_start), 0);
        check({tag, " char_addr"}, int'(char_addr), 0);
        check({tag, " font_addr"}, int'(font_addr), 0);
    endtask

    initial begin
        fg_color = 12'hF00;
        bg_color = 12'h00F;
        cursor_col = 7'd1;
        cursor_row = 5'd1;
        cursor_en = 1'b1;
        ce_run = 1'b1;
        repeat (12) @(negedge ACLK);
        check_reset("in_reset");
        // Frame 0 renders with the cleared latched colours
        q.push_back('{2, 6, 0});
        px(0, 0, 0, 6, 1);
        q.push_back('{4, 6, 0});
        px(0, 16, 35, 3, 1);
        px(0, 16, 35, 0, 12'h000);
        // Frame 1: fg=F00 bg=00F, blink phase off
        px(1, 33, 5, 1, 1);
        px(1, 34, 5, 1, 0);
        px(1, 37, 5, 1, 0);
        px(1, 38, 5, 1, 1);
        px(1, 8, 16, 0, 12'h00F);
        px(1, 17, 35, 4, 10);
        px(1, 16, 35, 0, 12'hF00);
        px(1, 17, 35, 5, 12'h413);
        px(1, 17, 35, 0, 12'h00F);
        px(1, 31, 35, 3, 1);
        px(1, 32, 35, 3, 0);
        px(1, 0, 49, 2, 1);
        px(1, 0, 50, 2, 0);
        px(1, 39, 51, 2, 0);
        px(1, 0, 52, 2, 1);
        // Frame 2: new colours fg=FFF bg=000, blink phase on, cursor cell (1,1) inverted
        px(2, 0, 0, 0, 12'h000);
        px(2, 8, 15, 0, 12'h000);
        for (int y = 16; y < 32; y++)
            for (int x = 7; x < 17; x++)
                px(2, x, y, 0, (x >= 8 && x <= 15) ? 12'hFFF : 12'h000);
        px(2, 8, 32, 0, 12'h000);
        px(2, 16, 35, 0, 12'hFFF);
        px(2, 17, 35, 0, 12'h000);
        // Frame 3: cursor column out of range; frame 4: blink phase back off
        px(3, 8, 16, 0, 12'h000);
        px(3, 15, 31, 0, 12'h000);
        px(4, 8, 16, 0, 12'h000);
        @(negedge ACLK);
        ARESETN = 1'b1;
        wait_tick(F + 20 * HT);
        fg_color = 12'hFFF;
        bg_color = 12'h000;
        wait_tick(2 * F + 40 * HT);
        cursor_col = 7'd5;
        wait_tick(3 * F + 40 * HT);
        cursor_col = 7'd1;
        wait_tick(4 * F + 35 * HT + 16 + 3);
        ce_run = 1'b0;
        repeat (50) @(negedge ACLK);
        check("frozen rgb", int'({red, green, blue}), 12'hFFF);
        check("frozen char_addr", int'(char_addr), 10);
        check("frozen font_addr", int'(font_addr), 12'h413);
        check("frozen video_on", int'(video_on), 1);
        check("frozen hsync", int'(hsync), 1);
        check("frozen frame_start", int'(frame_start), 0);
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        check_reset("async_reset");
        check("queue drained before reset", q.size(), 0);
        ce_run = 1'b1;
        q.push_back('{2, 6, 0});
        px(0, 0, 0, 6, 1);
        px(0, 33, 0, 1, 1);
        px(0, 34, 0, 1, 0);
        px(0, 17, 35, 4, 10);
        px(0, 16, 35, 0, 12'h000);
        repeat (8) @(negedge ACLK);
        ARESETN = 1'b1;
        wait_tick(1500);
        check("hsync low ticks in 2 frames", hs_low, 2 * VT * 4);
        check("vsync low ticks in 2 frames", vs_low, 2 * 2 * HT);
        check("video_on ticks in 2 frames", von_cnt, 2 * 32 * 48);
        check("frame_start pulse cycles", fs_cnt, 6);
        while (q.size() > 0) begin
            vectors++;
            errors++;
            $display("FAIL %s @tick %0d: never sampled, expected 0x%0h", names[q[0].k], q[0].t, q[0].v);
            void'(q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
